// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and bit-timing helper
// Contents:
//   S_* localparams : 3-bit state codes shared by uart_rx and uart_tx
//   uart_state_t    : enum built from those codes
//   cycles_per_bit  : clk cycles per serial bit for a given clock/baud pair
package uart_pkg;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    typedef enum logic [2:0] {
        IDLE       = S_IDLE,
        START      = S_START,
        DATA       = S_DATA,
        PARITY     = S_PARITY,
        STOP       = S_STOP,
        BREAK_WAIT = S_BREAK_WAIT
    } uart_state_t;

    function automatic int cycles_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte bundle for uart_rx
// Signals:
//   rx            : asynchronous serial line, idles high
//   data          : last correctly framed byte
//   data_valid    : one-cycle pulse, data updated
//   framing_error : one-cycle pulse, stop bit sampled low
//   parity_error  : one-cycle pulse, parity mismatch
//   busy          : receiver not idle
// Modports: master = receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       parity_error;
    logic       busy;

    modport master (
        input  rx,
        output data, data_valid, framing_error, parity_error, busy
    );

    modport slave (
        output rx,
        input  data, data_valid, framing_error, parity_error, busy
    );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the rx line, resets to idle-high
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronised output (2 cycles of latency)
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling; optional parity via UART_RX_PARITY_EN
// Ports:
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : uart_rx_if.master (rx in; data, data_valid, framing_error, parity_error, busy out)
// Parameters: CLOCK_FREQ, BAUD_RATE, PARITY_ODD (0 even / 1 odd, only with UART_RX_PARITY_EN).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    uart_rx_if.master   bus
);
    localparam int          CYCLES_PER_BIT = cycles_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int          HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam logic [15:0] BIT_LAST       = 16'(CYCLES_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST      = 16'(HALF_BIT - 1);

    uart_state_t state;
    logic        rx_s;
    logic [15:0] cycle_count;
    logic [2:0]  bit_count;
    logic [7:0]  shift_reg;
    logic [7:0]  data_q;
    logic        data_valid_q;
    logic        framing_error_q;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.rx),
        .q     (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    logic parity_error_q;
`else
    wire unused_parity_cfg = PARITY_ODD;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cycle_count     <= '0;
            bit_count       <= '0;
            shift_reg       <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bad      <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_error_q  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state       <= START;
                        cycle_count <= '0;
                    end
                end
                START: begin
                    if (cycle_count == HALF_LAST) begin
                        cycle_count <= '0;
                        bit_count   <= '0;
                        // A start bit that is no longer low at its midpoint is a glitch.
                        state       <= rx_s ? IDLE : DATA;
                    end else begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                end
                DATA: begin
                    if (cycle_count == BIT_LAST) begin
                        cycle_count <= '0;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_count   <= bit_count + 3'd1;
                        if (bit_count == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cycle_count == BIT_LAST) begin
                        cycle_count <= '0;
                        parity_bad  <= rx_s != (^shift_reg ^ PARITY_ODD);
                        state       <= STOP;
                    end else begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (cycle_count == BIT_LAST) begin
                        cycle_count <= '0;
                        if (rx_s) begin
                            data_q       <= shift_reg;
                            data_valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error_q <= parity_bad;
`endif
                            // Leaving mid-stop-bit lets a following start bit arrive with no gap.
                            state        <= IDLE;
                        end else begin
                            framing_error_q <= 1'b1;
                            state           <= BREAK_WAIT;
                        end
                    end else begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                end
                BREAK_WAIT: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data          = data_q;
    assign bus.data_valid    = data_valid_q;
    assign bus.framing_error = framing_error_q;
    assign bus.busy          = (state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error  = parity_error_q;
`else
    assign bus.parity_error  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
    localparam int CPB        = 16;
    localparam bit PARITY_ODD = 1'b0;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   start_cyc = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        int kind;   // 0 = data_valid, 1 = framing_error, 2 = parity_error
        int data;
        int cyc;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_FREQ (1600000),
        .BAUD_RATE  (100000),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_valid)    obs_q.push_back('{0, int'(bus.data), cyc});
            if (bus.parity_error)  obs_q.push_back('{2, 0, cyc});
            if (bus.framing_error) obs_q.push_back('{1, 0, cyc});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame-level reference: a good stop bit delivers the byte (plus a parity
    // complaint if the parity bit disagrees); a low stop bit is a framing error only.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic pbit);
        logic perr;
        int   ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        perr = (pbit != ((ones % 2 == 1) ^ PARITY_ODD));
        if (stop) begin
            exp_q.push_back('{0, int'(b), 0});
`ifdef UART_RX_PARITY_EN
            if (perr) exp_q.push_back('{2, 0, 0});
`endif
            last_good = b;
        end else begin
            exp_q.push_back('{1, 0, 0});
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit);
        start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit, CPB);
`endif
        drive_bit(stop, CPB);
        model_frame(b, stop, pbit);
    endtask

    task automatic expect_events(input string tag);
        int n;
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_kind%0d", tag, i), obs_q[i].kind, exp_q[i].kind);
            check_eq($sformatf("%s_data%0d", tag, i), obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int lat;
        logic [7:0] b;
        logic       stop;
        logic       pbit;

        bus.rx = 1'b1;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data", bus.data, 8'h00);
        check_eq("rst_valid", bus.data_valid, 1'b0);
        check_eq("rst_ferr", bus.framing_error, 1'b0);
        check_eq("rst_perr", bus.parity_error, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1, 10);

        // Single frame and its latency from the start edge.
        send_frame(8'h55, 1'b1, 1'b0);
        if (obs_q.size() > 0) begin
            lat = obs_q[0].cyc - start_cyc;
            check_eq("lat_55_in_range", (lat >= 150 && lat <= 170), 1'b1);
        end else begin
            check_eq("lat_55_seen", 0, 1);
        end
        expect_events("f55");
        check_eq("data_55", bus.data, 8'h55);

        // Short low glitch must be rejected silently.
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 30);
        check_eq("glitch_busy", bus.busy, 1'b0);
        expect_events("glitch");
        check_eq("glitch_data", bus.data, 8'h55);

        // Bad stop bit followed by a held break.
        send_frame(8'hA3, 1'b0, 1'b0);
        drive_bit(1'b0, 100);
        check_eq("break_busy", bus.busy, 1'b1);
        drive_bit(1'b1, 8);
        expect_events("brk");
        check_eq("brk_data", bus.data, 8'h55);
        check_eq("brk_idle", bus.busy, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        drive_bit(1'b1, 4);
        expect_events("f3c");
        check_eq("data_3c", bus.data, 8'h3C);

        // Back-to-back frames, no idle between stop and next start.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        drive_bit(1'b1, 4);
        expect_events("b2b");
        check_eq("data_ff", bus.data, 8'hFF);

        // Reset in the middle of bit 4 of 0x81 discards the frame.
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(((8'h81 >> i) & 8'h01) != 0, CPB);
        drive_bit(1'b0, CPB / 2);
        reset  = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        last_good = 8'h00;
        drive_bit(1'b1, 8);
        check_eq("abort_data", bus.data, 8'h00);
        check_eq("abort_busy", bus.busy, 1'b0);
        expect_events("abort");
        send_frame(8'h7E, 1'b1, 1'b0);
        drive_bit(1'b1, 4);
        expect_events("f7e");
        check_eq("data_7e", bus.data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        drive_bit(1'b1, 4);
        expect_events("par_ok");
        send_frame(8'h07, 1'b1, 1'b0);
        drive_bit(1'b1, 4);
        if (obs_q.size() == 2)
            check_eq("par_same_cycle", obs_q[0].cyc == obs_q[1].cyc, 1'b1);
        expect_events("par_bad");
`endif

        // Randomized frames with random gaps and occasional bad stop bits.
        for (int n = 0; n < 24; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            pbit = 1'($urandom);
            send_frame(b, stop, pbit);
            if (!stop) begin
                drive_bit(1'b0, $urandom_range(0, 40));
                drive_bit(1'b1, 8);
            end else begin
                drive_bit(1'b1, $urandom_range(0, 10));
            end
        end
        drive_bit(1'b1, 8);
        expect_events("rand");
        check_eq("rand_data", bus.data, last_good);
        check_eq("rand_busy", bus.busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive end of the team's 8N1 serial link, paired with uart_tx.
- Synchronises the asynchronous rx line into clk.
- Detects the start bit and samples each bit at its midpoint.
- Assembles 8 data bits, LSB first, then checks the stop bit.
- Presents each received byte with a one-cycle valid pulse to the consumer (UART bridge / command decoder).

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
CYCLES_PER_BIT, CLOCK_FREQ/BAUD_RATE, clk cycles per bit (5208 at defaults); must be >= 4
HALF_BIT, CYCLES_PER_BIT/2, cycles from start-edge detection to start-bit midpoint
PARITY_ODD, 0, 0 = even parity, 1 = odd; used only when UART_RX_PARITY_EN is defined

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
data  output  8  last correctly framed byte; held until the next good frame
data_valid  output  1  one-cycle pulse: data updated this cycle
framing_error  output  1  one-cycle pulse: stop bit sampled low
parity_error  output  1  one-cycle pulse: parity mismatch; constant 0 without the macro
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - data=0x00; data_valid, framing_error, parity_error and busy = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
- Reset while mid-frame: next edge returns to IDLE; the partial byte is discarded and no pulse is emitted.
- rx passes through 2 flops (rx_s). All decisions use rx_s, giving 2 cycles of input latency.
- cycle_count is 16 bits; bit_count is 3 bits.
- State machine:
  - IDLE: if rx_s==0 -> START, cycle_count=0.
  - START: count to HALF_BIT-1, then resample.
    - rx_s==0 -> DATA, cycle_count=0, bit_count=0.
    - rx_s==1 -> IDLE; glitch rejected, no pulse.
  - DATA: at cycle_count==CYCLES_PER_BIT-1 (mid-bit), shift_reg <= {rx_s, shift_reg[7:1]} and reset cycle_count.
    - After bit_count==7 -> STOP, or PARITY when the macro is defined.
  - STOP: at CYCLES_PER_BIT-1, sample rx_s.
    - 1 -> data<=shift_reg, data_valid=1 for one cycle, -> IDLE.
    - 0 -> framing_error=1 for one cycle, data unchanged, -> BREAK_WAIT.
  - BREAK_WAIT: stay until rx_s==1, then -> IDLE. A held-low line (break) yields exactly one framing_error.
- Pulse timing: pulses assert on the edge after the stop-bit sample and deassert the following cycle.
- Back-to-back frames: the next start bit is accepted as soon as IDLE is re-entered, half a bit before the stop bit ends, so zero idle time between frames is supported.
- Frame time: about 10 bit times (11 with parity) from the start edge to data_valid.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP; the parity bit is sampled mid-bit at CYCLES_PER_BIT-1.
  - Expected parity = ^shift_reg ^ PARITY_ODD.
  - At a good stop bit: data_valid pulses and data updates. On mismatch, parity_error pulses in the same cycle.
  - A bad stop bit gives framing_error only; parity_error is suppressed.
- Undefined: no PARITY state; parity_error tied 0; frame is 8N1.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT; 3-bit).
  - cycles-per-bit constant function, reused by uart_tx.
- One sub-module: uart_rx_sync, a 2-flop synchroniser with reset value 1.

Test Plan (sim with CLOCK_FREQ=1600000, BAUD_RATE=100000, so CYCLES_PER_BIT=16):
- Send 0x55 as 8N1 -> exactly one data_valid pulse, data=0x55, about 160 cycles after the start edge; framing_error stays 0.
- Pull rx low for 4 cycles, then high -> returns to IDLE with busy dropping; no pulses; data unchanged.
- Send 0xA3 with stop bit 0, then hold rx low for 100 cycles -> one framing_error pulse, data keeps its previous value. Then send 0x3C -> data_valid with data=0x3C.
- Send 0x00 and 0xFF back-to-back with no idle gap -> two data_valid pulses carrying 0x00 then 0xFF.
- Assert reset during bit 4 of 0x81, then send 0x7E -> no pulse for the aborted frame; 0x7E received correctly.
- With UART_RX_PARITY_EN and PARITY_ODD=0:
  - 0x07 with parity bit 1 -> data_valid only.
  - 0x07 with parity bit 0 -> data_valid and parity_error pulse in the same cycle.
